conv_pass_scheduler: RTL and testbench

// - Sequences repeated passes of the 5x5 FP16 column-parallel convolution engine over one 28x28 image, one kernel slot per pass.
// - Per pass: pulses the engine start, collects its output columns and writes them to the result buffer.
// - Checks column order/count, runs a hang watchdog, reports completion or error to the host.
// - Sits between the host command interface and the convolution engine.

---
 rtl/conv_pass_scheduler.sv | 148 ++++++++++++++
 tb/tb_conv_pass_scheduler.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/conv_pass_scheduler.sv
// conv_pass_scheduler: sequences engine passes over one image, writes result columns, checks order/count, watchdog and abort.
module conv_pass_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_COLS   = 24,
  parameter int MAX_PASSES = 8,
  parameter int TIMEOUT    = 4095,
  localparam int PW  = $clog2(MAX_PASSES),
  localparam int CNW = $clog2(OUT_COLS+4)+1,
  localparam int AW  = $clog2(MAX_PASSES*OUT_COLS),
  localparam int DW  = OUT_COLS*DATA_WIDTH,
  localparam int CW  = $clog2(OUT_COLS+1),
  localparam int WW  = $clog2(TIMEOUT+1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  input  logic [PW:0]    cmd_passes,
  output logic           cmd_ready,
  input  logic           abort,
  output logic           eng_start,
  output logic [PW-1:0]  eng_kernel_sel,
  input  logic           eng_valid_col,
  input  logic [CNW-1:0] eng_col_num,
  input  logic [DW-1:0]  eng_col_data,
  input  logic           eng_done,
  output logic           res_we,
  output logic [AW-1:0]  res_addr,
  output logic [DW-1:0]  res_data,
  output logic           busy,
  output logic           done,
  output logic           error,
  output logic [1:0]     err_code
);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, RUN = 3'd2, NEXT = 3'd3, FINISH = 3'd4, ERR = 3'd5;
  logic [2:0]    state_q, state_d;
  logic [PW:0]   passes_q, passes_d;
  logic [PW-1:0] pass_q, pass_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          we_q, we_d, error_q, error_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [1:0]    code_q, code_d, ec;
  logic          eg, col_ok;
  assign cmd_ready      = state_q == IDLE;
  assign busy           = state_q != IDLE;
  assign eng_start      = state_q == START;
  assign done           = state_q == FINISH;
  assign eng_kernel_sel = pass_q;
  assign res_we         = we_q;
  assign res_addr       = addr_q;
  assign res_data       = data_q;
  assign error          = error_q;
  assign err_code       = code_q;
  assign col_ok = eng_col_num == CNW'(cnt_q) + CNW'(1) && 32'(cnt_q) != OUT_COLS;
  always_comb begin
    state_d  = state_q;
    passes_d = passes_q;
    pass_d   = pass_q;
    cnt_d    = cnt_q;
    wd_d     = wd_q;
    we_d     = 1'b0;
    error_d  = error_q;
    code_d   = code_q;
    eg       = 1'b0;
    ec       = 2'd0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        passes_d = cmd_passes;
        pass_d   = '0;
        if (cmd_passes == 0 || 32'(cmd_passes) > MAX_PASSES) begin
          eg = 1'b1;
          ec = 2'd2;
        end else begin
          state_d = START;
          error_d = 1'b0;
          code_d  = 2'd0;
        end
      end
      START: begin
        cnt_d   = '0;
        wd_d    = '0;
        state_d = RUN;
      end
      RUN: begin
        wd_d = (eng_valid_col || eng_done) ? '0 : wd_q + WW'(1);
        if (eng_valid_col && !col_ok) begin
          eg = 1'b1;
          ec = 2'd1;
        end else begin
          we_d  = eng_valid_col;
          cnt_d = cnt_q + CW'(eng_valid_col);
          if (eng_done) begin
            state_d = 32'(cnt_d) == OUT_COLS ? NEXT : state_q;
            eg      = 32'(cnt_d) != OUT_COLS;
            ec      = 2'd2;
          end else if (!eng_valid_col && 32'(wd_q) + 1 == TIMEOUT) begin
            eg = 1'b1;
            ec = 2'd3;
          end
        end
      end
      NEXT: begin
        pass_d  = pass_q + PW'(1);
        state_d = (PW+1)'(pass_q) + (PW+1)'(1) == passes_q ? FINISH : START;
      end
      default: state_d = IDLE;
    endcase
    // abort overrides anything this cycle, including a column accepted alongside it
    if (abort && state_q != IDLE && state_q != ERR) begin
      eg = 1'b1;
      ec = 2'd3;
    end
    if (eg) begin
      state_d = ERR;
      error_d = 1'b1;
      code_d  = ec;
      we_d    = 1'b0;
    end
    addr_d = we_d ? AW'(32'(pass_q)*OUT_COLS + 32'(cnt_q)) : addr_q;
    data_d = we_d ? eng_col_data : data_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      passes_q <= '0;
      pass_q   <= '0;
      cnt_q    <= '0;
      wd_q     <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      error_q  <= 1'b0;
      code_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      passes_q <= passes_d;
      pass_q   <= pass_d;
      cnt_q    <= cnt_d;
      wd_q     <= wd_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      error_q  <= error_d;
      code_q   <= code_d;
    end
  end
endmodule

// File: tb/tb_conv_pass_scheduler.sv
// tb_conv_pass_scheduler: directed checks of pass sequencing, result writes, error codes, abort and async reset.
module tb_conv_pass_scheduler;
  logic         clk = 1'b0, rst = 1'b1;
  logic         cmd_valid = 1'b0, abort = 1'b0;
  logic [3:0]   cmd_passes = '0;
  logic         cmd_ready, eng_start, res_we, busy, done, error;
  logic [2:0]   eng_kernel_sel;
  logic         eng_valid_col = 1'b0, eng_done = 1'b0;
  logic [5:0]   eng_col_num = '0;
  logic [383:0] eng_col_data = '0, res_data, d;
  logic [7:0]   res_addr;
  logic [1:0]   err_code;
  int total = 0, bad = 0;
  conv_pass_scheduler dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_passes(cmd_passes), .cmd_ready(cmd_ready),
    .abort(abort), .eng_start(eng_start), .eng_kernel_sel(eng_kernel_sel), .eng_valid_col(eng_valid_col),
    .eng_col_num(eng_col_num), .eng_col_data(eng_col_data), .eng_done(eng_done), .res_we(res_we),
    .res_addr(res_addr), .res_data(res_data), .busy(busy), .done(done), .error(error), .err_code(err_code)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic rnd;
    for (int i = 0; i < 12; i++) d[i*32 +: 32] = $urandom;
  endtask
  task automatic send_cmd(input int n);
    chk("cmd_ready", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_passes = 4'(n);
    tick;
    cmd_valid  = 1'b0;
  endtask
  task automatic col(input int c);
    rnd;
    eng_valid_col = 1'b1;
    eng_col_num   = 6'(c);
    eng_col_data  = d;
    tick;
    eng_valid_col = 1'b0;
  endtask
  task automatic run_pass(input int p);
    chk("start", eng_start, 1);
    chk("ksel", eng_kernel_sel, p);
    tick;
    chk("start_pulse", eng_start, 0);
    for (int c = 1; c <= 24; c++) begin
      col(c);
      chk("we", res_we, 1);
      chk("addr", res_addr, p*24 + c - 1);
      chk("data", res_data, d);
    end
    eng_done = 1'b1;
    tick;
    eng_done = 1'b0;
    chk("we_after", res_we, 0);
    chk("ksel_hold", eng_kernel_sel, p);
  endtask
  initial begin
    #12;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_start", eng_start, 0);
    chk("rst_we", res_we, 0);
    chk("rst_err", {error, err_code}, 0);
    chk("rst_addr", res_addr, 0);
    rst = 1'b0;
    tick;
    abort = 1'b1;
    eng_valid_col = 1'b1;
    eng_col_num = 6'd1;
    tick;
    abort = 1'b0;
    eng_valid_col = 1'b0;
    chk("idle_ignore", {cmd_ready, res_we, error, busy}, 4'b1000);
    send_cmd(1);
    run_pass(0);
    tick;
    chk("done1", done, 1);
    tick;
    chk("done1_pulse", {done, busy, error}, 0);
    send_cmd(3);
    for (int p = 0; p < 3; p++) begin
      run_pass(p);
      tick;
      chk("done3", done, p == 2);
    end
    tick;
    chk("idle3", {done, busy, error}, 0);
    send_cmd(1);
    tick;
    col(1);
    col(2);
    chk("we_col2", res_we, 1);
    col(4);
    chk("order_we", res_we, 0);
    chk("order_err", {busy, error, err_code}, 4'b1101);
    tick;
    chk("order_idle", {busy, error, err_code}, 4'b0101);
    send_cmd(1);
    chk("err_clear", {error, err_code}, 0);
    tick;
    for (int c = 1; c <= 23; c++) col(c);
    eng_done = 1'b1;
    tick;
    eng_done = 1'b0;
    chk("count_err", {error, err_code}, 3'b110);
    tick;
    send_cmd(0);
    chk("zero_pass", {eng_start, error, err_code}, 4'b0110);
    tick;
    send_cmd(9);
    chk("nine_pass", {eng_start, error, err_code}, 4'b0110);
    tick;
    send_cmd(1);
    tick;
    repeat (4094) tick;
    chk("wd_early", {busy, error}, 2'b10);
    tick;
    chk("timeout", {error, err_code}, 3'b111);
    tick;
    send_cmd(1);
    tick;
    col(1);
    rnd;
    eng_valid_col = 1'b1;
    eng_col_num   = 6'd2;
    eng_col_data  = d;
    abort         = 1'b1;
    tick;
    eng_valid_col = 1'b0;
    abort         = 1'b0;
    chk("abort_we", res_we, 0);
    chk("abort_err", {error, err_code}, 3'b111);
    tick;
    send_cmd(3);
    run_pass(0);
    tick;
    tick;
    col(1);
    chk("pre_rst_we", {res_we, eng_kernel_sel}, 4'b1001);
    #2 rst = 1'b1;
    #1;
    chk("arst_ctl", {cmd_ready, busy, eng_start, res_we, done, error}, 6'b100000);
    chk("arst_val", {eng_kernel_sel, res_addr, err_code}, 0);
    chk("arst_data", res_data, 0);
    tick;
    rst = 1'b0;
    tick;
    send_cmd(1);
    run_pass(0);
    tick;
    chk("rerun_done", {done, error}, 2'b10);
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
